rank_order_aer_streamer: RTL

Parametrised rank-order input streamer for the SNN accelerator front end. It latches a full input image and emits pixel indices in descending intensity order, lowest index first within a level, as events on a 4-phase AER output link. Pixels below a programmable floor are dropped, and an optional end-of-image marker event is appended. An internal event FIFO decouples the one-event-per-cycle sort engine from the slower AER handshake.

---
 rtl/rank_order_aer_streamer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rank_order_aer_streamer.sv
// Rank-order input streamer: latches an image, emits pixel indices brightest-first
// (lowest index first within a level) as 4-phase AER events through a small FIFO.
module rank_order_aer_streamer #(
    parameter int IMAGE_SIZE = 256,
    parameter int PIXEL_BITS = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_LEVEL  = 1,
    parameter int EOF_EVENT  = 1,
    parameter int CNT_BITS   = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PIXEL_BITS-1:0] IMAGE [0:IMAGE_SIZE-1],
    input  logic                  NEW_IMAGE,
    input  logic                  INFERENCE_RDY,
    output logic                  ENCODER_RDY,
    output logic [CNT_BITS-1:0]   EVENT_COUNT,
    output logic [ADDR_WIDTH-1:0] AERIN_ADDR,
    output logic                  AERIN_REQ,
    input  logic                  AERIN_ACK
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (IMAGE_SIZE > (2 ** ADDR_WIDTH) - 1) begin : g_bad_addr_width
        $error("IMAGE_SIZE must not exceed 2**ADDR_WIDTH-1");
    end
    if (FIFO_DEPTH < 2 || (2 ** PTR_W) != FIFO_DEPTH) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EOF, S_DRAIN} state_t;

    state_t                  state;
    logic [PIXEL_BITS-1:0]   pixels [0:IMAGE_SIZE-1];
    logic [IMAGE_SIZE-1:0]   sent;
    logic [PIXEL_BITS-1:0]   level;
    logic                    match_any;
    logic [ADDR_WIDTH-1:0]   match_idx;

    logic [ADDR_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          fifo_count;
    logic                    fifo_full;
    logic [ADDR_WIDTH-1:0]   fifo_head;
    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH-1:0]   push_data;

    logic                    ack_meta;
    logic                    ack_s;
    logic                    accept;
    logic                    scan_active;

    assign accept      = (state == S_IDLE) && NEW_IMAGE;
    assign fifo_full   = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign fifo_head   = fifo_mem[rd_ptr];
    assign scan_active = (state == S_SCAN) && INFERENCE_RDY && !fifo_full;
    assign push        = (scan_active && match_any) || ((state == S_EOF) && !fifo_full);
    assign push_data   = (state == S_EOF) ? '1 : match_idx;
    assign pop         = AERIN_REQ && ack_s;

    // Descending loop so the last hit written is the lowest unsent index at this level.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = IMAGE_SIZE - 1; i >= 0; i--) begin
            if (pixels[i] == level && !sent[i]) begin
                match_any = 1'b1;
                match_idx = ADDR_WIDTH'(i);
            end
        end
    end

    // NOTE: the image store and FIFO storage carry no reset; the sent mask, pointers
    // and occupancy count define which entries are meaningful.
    always_ff @(posedge CLK) begin
        if (accept) begin
            pixels <= IMAGE;
        end
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            ENCODER_RDY <= 1'b1;
            sent        <= '0;
            level       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (NEW_IMAGE) begin
                        sent        <= '0;
                        level       <= '1;
                        ENCODER_RDY <= 1'b0;
                        state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_active) begin
                        if (match_any) begin
                            sent[match_idx] <= 1'b1;
                        end else if (level == PIXEL_BITS'(MIN_LEVEL)) begin
                            state <= (EOF_EVENT != 0) ? S_EOF : S_DRAIN;
                        end else begin
                            level <= level - 1'b1;
                        end
                    end
                end
                S_EOF: begin
                    if (!fifo_full) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == '0 && !AERIN_REQ && !ack_s) begin
                        state       <= S_IDLE;
                        ENCODER_RDY <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ACK arrives from another clock domain; two flops before any use.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= AERIN_ACK;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AERIN_REQ   <= 1'b0;
            AERIN_ADDR  <= '0;
            EVENT_COUNT <= '0;
        end else begin
            if (accept) begin
                EVENT_COUNT <= '0;
            end else if (pop && fifo_head != '1) begin
                EVENT_COUNT <= EVENT_COUNT + 1'b1;
            end
            if (pop) begin
                AERIN_REQ <= 1'b0;
            end else if (!AERIN_REQ && !ack_s && fifo_count != '0) begin
                AERIN_ADDR <= fifo_head;
                AERIN_REQ  <= 1'b1;
            end
        end
    end

endmodule
